// File: rtl/wave_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_meter_pkg
// Description : Shared definitions for the wave_meter block. Holds the default
//               sample width, the power-up threshold midpoint and the encoding
//               of the hysteresis crossing state machine.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_meter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int MID_RESET  = 128;

    // ARM: no history yet, the first valid sample decides LOW or HIGH
    typedef enum logic [1:0] {
        CROSS_ARM  = 2'd0,
        CROSS_LOW  = 2'd1,
        CROSS_HIGH = 2'd2
    } cross_state_e;

endpackage : wave_meter_pkg
`default_nettype wire

// File: rtl/hyst_crossing_detector.sv
`default_nettype none
// ============================================================================
// Module      : hyst_crossing_detector
// Description : Rising threshold-crossing detector with a hysteresis band of
//               +/-HYST around a programmable midpoint. Thresholds saturate at
//               the ends of the sample range.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset (state -> ARM)
//               sample  - unsigned sample
//               valid   - sample is valid; the FSM only advances when set
//               mid     - midpoint threshold
//               restart - force the FSM back to ARM on the next edge
//               rise    - one-cycle pulse on a LOW->HIGH transition
// Revision    : 1.0 - initial release
// ============================================================================
module hyst_crossing_detector
    import wave_meter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HYST   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              valid,
    input  logic [DATA_W-1:0] mid,
    input  logic              restart,
    output logic              rise
);

    localparam logic [DATA_W:0] HYST_EXT = (DATA_W+1)'(HYST);

    cross_state_e      state_q, state_d;
    logic [DATA_W:0]   hi_sum;
    logic [DATA_W:0]   lo_diff;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // One extra bit catches overflow of mid+HYST and borrow of mid-HYST
    always_comb begin
        hi_sum  = {1'b0, mid} + HYST_EXT;
        lo_diff = {1'b0, mid} - HYST_EXT;
        hi      = hi_sum[DATA_W]  ? '1 : hi_sum[DATA_W-1:0];
        lo      = lo_diff[DATA_W] ? '0 : lo_diff[DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        if (valid) begin
            case (state_q)
                CROSS_ARM:  state_d = (sample >= mid) ? CROSS_HIGH : CROSS_LOW;
                CROSS_LOW: begin
                    if (sample >= hi) begin
                        state_d = CROSS_HIGH;
                        rise    = 1'b1;
                    end
                end
                CROSS_HIGH: begin
                    if (sample <= lo) begin
                        state_d = CROSS_LOW;
                    end
                end
                default:    state_d = CROSS_ARM;
            endcase
        end
        if (restart) begin
            state_d = CROSS_ARM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CROSS_ARM;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : hyst_crossing_detector
`default_nettype wire

// File: rtl/wave_meter.sv
`default_nettype none
// ============================================================================
// Module      : wave_meter
// Description : Measures an unsigned sampled waveform over a fixed gate window:
//               counts rising hysteresis crossings and tracks min/max, then
//               latches freq_count, vmax, vmin and vpp at the window end.
// Ports       : sys_clk      - rising-edge clock
//               reset        - asynchronous active-low reset
//               sample_in    - waveform sample (unsigned)
//               sample_valid - sample_in valid this cycle
//               freq_count   - rising crossings in the last completed window
//               vmax / vmin  - extreme samples of the last window
//               vpp          - vmax - vmin
//               meas_valid   - one-cycle pulse when the outputs update
//               signal_lost  - last window had zero crossings
// Revision    : 1.0 - initial release
// ============================================================================
module wave_meter
    import wave_meter_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CNT_W       = 24,
    parameter int GATE_CYCLES = 1000000,
    parameter int HYST        = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [CNT_W-1:0]  freq_count,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic              meas_valid,
    output logic              signal_lost
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [DATA_W-1:0] MID_INIT  = (DATA_W == DATA_W_DEF) ? DATA_W'(MID_RESET)
                                                                     : {1'b1, {(DATA_W-1){1'b0}}};

    logic [GATE_W-1:0] gate_q, gate_d;
    logic [DATA_W-1:0] mid_q, mid_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              seen_q, seen_d;
    logic [CNT_W-1:0]  freq_count_q, freq_count_d;
    logic [DATA_W-1:0] vmax_q, vmax_d;
    logic [DATA_W-1:0] vmin_q, vmin_d;
    logic [DATA_W-1:0] vpp_q, vpp_d;
    logic              meas_valid_q, meas_valid_d;
    logic              signal_lost_q, signal_lost_d;

    logic              tc;
    logic              rise;
    logic              restart;
    logic [DATA_W-1:0] max_upd;
    logic [DATA_W-1:0] min_upd;
    logic [CNT_W-1:0]  cnt_upd;
    logic              seen_upd;
    logic [DATA_W:0]   mid_sum;

    hyst_crossing_detector #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_cross (
        .clk     (sys_clk),
        .rst_n   (reset),
        .sample  (sample_in),
        .valid   (sample_valid),
        .mid     (mid_q),
        .restart (restart),
        .rise    (rise)
    );

    // *_upd include the current sample so the terminal-cycle sample lands in
    // the closing window's results.
    always_comb begin
        tc       = (gate_q == GATE_LAST);
        max_upd  = (sample_valid && (sample_in > run_max_q)) ? sample_in : run_max_q;
        min_upd  = (sample_valid && (sample_in < run_min_q)) ? sample_in : run_min_q;
        cnt_upd  = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        seen_upd = seen_q | sample_valid;
        mid_sum  = {1'b0, max_upd} + {1'b0, min_upd};
        restart  = tc && !seen_upd;
    end

    always_comb begin
        gate_d        = tc ? '0 : gate_q + GATE_W'(1);
        mid_d         = mid_q;
        run_max_d     = max_upd;
        run_min_d     = min_upd;
        edge_cnt_d    = cnt_upd;
        seen_d        = seen_upd;
        freq_count_d  = freq_count_q;
        vmax_d        = vmax_q;
        vmin_d        = vmin_q;
        vpp_d         = vpp_q;
        meas_valid_d  = tc;
        signal_lost_d = signal_lost_q;
        if (tc) begin
            freq_count_d  = cnt_upd;
            signal_lost_d = (cnt_upd == '0);
            run_max_d     = '0;
            run_min_d     = '1;
            edge_cnt_d    = '0;
            seen_d        = 1'b0;
            if (seen_upd) begin
                vmax_d = max_upd;
                vmin_d = min_upd;
                vpp_d  = max_upd - min_upd;
                mid_d  = mid_sum[DATA_W:1];
            end else begin
                vmax_d = '0;
                vmin_d = '0;
                vpp_d  = '0;
                mid_d  = MID_INIT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            gate_q        <= '0;
            mid_q         <= MID_INIT;
            run_max_q     <= '0;
            run_min_q     <= '1;
            edge_cnt_q    <= '0;
            seen_q        <= 1'b0;
            freq_count_q  <= '0;
            vmax_q        <= '0;
            vmin_q        <= '0;
            vpp_q         <= '0;
            meas_valid_q  <= 1'b0;
            signal_lost_q <= 1'b0;
        end else begin
            gate_q        <= gate_d;
            mid_q         <= mid_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            edge_cnt_q    <= edge_cnt_d;
            seen_q        <= seen_d;
            freq_count_q  <= freq_count_d;
            vmax_q        <= vmax_d;
            vmin_q        <= vmin_d;
            vpp_q         <= vpp_d;
            meas_valid_q  <= meas_valid_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign freq_count  = freq_count_q;
    assign vmax        = vmax_q;
    assign vmin        = vmin_q;
    assign vpp         = vpp_q;
    assign meas_valid  = meas_valid_q;
    assign signal_lost = signal_lost_q;

endmodule : wave_meter
`default_nettype wire

// File: tb/tb_wave_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_meter
// Description : Window-by-window directed test of wave_meter with a 1000-cycle
//               gate. Two instances share the stimulus: a 24-bit counter and a
//               4-bit counter that shows saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_meter;

    localparam int GATE = 1000;
    localparam int NV   = 10;

    localparam int M_SQ100     = 0;  // 0/255 square, period 100, low first
    localparam int M_SQ40      = 1;  // 0/255 square, period 40, rising edge at tc
    localparam int M_T100_135  = 2;
    localparam int M_T126_130  = 3;
    localparam int M_T100_120  = 4;
    localparam int M_IDLE      = 5;  // sample_valid low, junk on sample_in
    localparam int M_T130_100  = 6;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic [7:0]  sample_in    = 8'd0;
    logic        sample_valid = 1'b0;

    logic [23:0] freq_count;
    logic [7:0]  vmax, vmin, vpp;
    logic        meas_valid, signal_lost;

    logic [3:0]  freq_count4;
    logic [7:0]  vmax4, vmin4, vpp4;
    logic        meas_valid4, signal_lost4;

    always #5 sys_clk = ~sys_clk;

    wave_meter #(.DATA_W(8), .CNT_W(24), .GATE_CYCLES(GATE), .HYST(8)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .freq_count   (freq_count),
        .vmax         (vmax),
        .vmin         (vmin),
        .vpp          (vpp),
        .meas_valid   (meas_valid),
        .signal_lost  (signal_lost)
    );

    wave_meter #(.DATA_W(8), .CNT_W(4), .GATE_CYCLES(GATE), .HYST(8)) dut4 (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .freq_count   (freq_count4),
        .vmax         (vmax4),
        .vmin         (vmin4),
        .vpp          (vpp4),
        .meas_valid   (meas_valid4),
        .signal_lost  (signal_lost4)
    );

    typedef struct {
        int mode;
        int fc;
        int vmax;
        int vmin;
        int vpp;
        int lost;
        bit rst_mid;   // reset is pulled at gate cycle 500 of this window
    } vec_t;

    vec_t vec [NV];
    int   checks = 0;
    int   errors = 0;
    bit   release_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int mode, input int p);
        sample_valid = 1'b1;
        case (mode)
            M_SQ100:    sample_in = ((p % 100) < 50) ? 8'd0 : 8'd255;
            M_SQ40:     sample_in = (((p + 1) % 40) < 20) ? 8'd255 : 8'd0;
            M_T100_135: sample_in = ((p % 2) == 0) ? 8'd100 : 8'd135;
            M_T126_130: sample_in = ((p % 2) == 0) ? 8'd126 : 8'd130;
            M_T100_120: sample_in = ((p % 2) == 0) ? 8'd100 : 8'd120;
            M_T130_100: sample_in = ((p % 2) == 0) ? 8'd130 : 8'd100;
            default: begin
                sample_valid = 1'b0;
                sample_in    = 8'd255;
            end
        endcase
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_freq_count"},   32'(freq_count),   32'd0);
        chk({tag, "_vmax"},         32'(vmax),         32'd0);
        chk({tag, "_vmin"},         32'(vmin),         32'd0);
        chk({tag, "_vpp"},          32'(vpp),          32'd0);
        chk({tag, "_meas_valid"},   32'(meas_valid),   32'd0);
        chk({tag, "_signal_lost"},  32'(signal_lost),  32'd0);
        chk({tag, "_freq_count4"},  32'(freq_count4),  32'd0);
        chk({tag, "_meas_valid4"},  32'(meas_valid4),  32'd0);
    endtask

    task automatic check_window(input int w, input vec_t v);
        int fc4;
        fc4 = (v.fc > 15) ? 15 : v.fc;
        $display("window %0d: freq_count=%0d vmax=%0d vmin=%0d vpp=%0d lost=%0d",
                 w, freq_count, vmax, vmin, vpp, signal_lost);
        chk($sformatf("w%0d_meas_valid", w),  32'(meas_valid),  32'd1);
        chk($sformatf("w%0d_freq_count", w),  32'(freq_count),  32'(v.fc));
        chk($sformatf("w%0d_vmax", w),        32'(vmax),        32'(v.vmax));
        chk($sformatf("w%0d_vmin", w),        32'(vmin),        32'(v.vmin));
        chk($sformatf("w%0d_vpp", w),         32'(vpp),         32'(v.vpp));
        chk($sformatf("w%0d_signal_lost", w), 32'(signal_lost), 32'(v.lost));
        chk($sformatf("w%0d_freq_count4", w), 32'(freq_count4), 32'(fc4));
        chk($sformatf("w%0d_meas_valid4", w), 32'(meas_valid4), 32'd1);
    endtask

    initial begin
        // Reset -> ARM, mid 128: 0 goes LOW, then 10 rises; next mid (255+0)>>1 = 127
        vec[0] = '{M_SQ100,    10, 255,   0, 255, 0, 1'b0};
        // Starts HIGH from the previous window; 25 rises, the last on tc
        vec[1] = '{M_SQ40,     25, 255,   0, 255, 0, 1'b0};
        // mid 127 -> hi 135: every 135 after a 100 counts (would not with hi 136)
        vec[2] = '{M_T100_135, 500, 135, 100,  35, 0, 1'b0};
        // mid 117 -> lo 109: stuck HIGH, no rises
        vec[3] = '{M_T126_130,  0, 130, 126,   4, 1, 1'b0};
        // mid 128 -> hi 136: drops to LOW, 120 never reaches hi; next mid 110
        vec[4] = '{M_T100_120,  0, 120, 100,  20, 1, 1'b0};
        // No valid samples: outputs clear, mid back to 128, FSM to ARM
        vec[5] = '{M_IDLE,      0,   0,   0,   0, 1, 1'b0};
        // From ARM with mid 128: 130 -> HIGH, 100 -> LOW, 130 < 136 never rises
        vec[6] = '{M_T130_100,  0, 130, 100,  30, 1, 1'b0};
        // Aborted by reset at gate cycle 500; no results expected
        vec[7] = '{M_SQ100,     0,   0,   0,   0, 0, 1'b1};
        // Fresh window after release, results one full window later
        vec[8] = '{M_SQ100,    10, 255,   0, 255, 0, 1'b0};
        // Trailing window only collects the results of vec[8]
        vec[9] = '{M_IDLE,      0,   0,   0,   0, 1, 1'b0};

        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        release_pending = 1'b1;

        // Reset is released on a falling edge; the gate=0 cycle is the first
        // cycle of the window, so tc is the 1000th cycle and meas_valid must
        // show up right after the 1000th rising edge, and nowhere else.
        for (int i = 0; i < NV; i++) begin
            int stray;
            stray = 0;
            for (int p = 0; p < GATE; p++) begin
                @(negedge sys_clk);
                if (release_pending) begin
                    reset           = 1'b1;
                    release_pending = 1'b0;
                end
                if (p == 0 && i > 0 && !vec[i-1].rst_mid) begin
                    check_window(i - 1, vec[i-1]);
                end else if (meas_valid || meas_valid4) begin
                    stray++;
                end
                if (vec[i].rst_mid && p == 500) begin
                    reset = 1'b0;
                    #1;
                    check_outputs_zero("async_reset");
                    for (int k = 0; k < 3; k++) begin
                        @(negedge sys_clk);
                        chk("reset_hold_meas_valid", 32'(meas_valid), 32'd0);
                    end
                    release_pending = 1'b1;
                    break;
                end
                drive(vec[i].mode, p);
            end
            chk($sformatf("w%0d_no_stray_meas_valid", i), 32'(stray), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wave_meter
`default_nettype wire

// File: doc/wave_meter.md
Name: wave_meter

Overview:
- Measurement-side counterpart of the DDS signal generator: consumes an 8-bit sampled waveform and reports frequency and amplitude.
- Over a fixed gate window of sys_clk cycles it:
  - counts rising threshold crossings, using hysteresis;
  - tracks the minimum and maximum sample;
  - latches frequency count, vmax, vmin and vpp at the window end.
- Sits after the wave source (generator output or ADC capture) and feeds the display/readout logic.

Parameters:
- DATA_W, 8, sample width.
- CNT_W, 24, width of the crossing counter.
- GATE_CYCLES, 1000000, gate window length in sys_clk cycles (>= 2).
- HYST, 8, hysteresis half-band in LSBs around the midpoint threshold.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_in  input  DATA_W  waveform sample, unsigned.
- sample_valid  input  1  sample_in is valid this cycle.
- freq_count  output  CNT_W  rising crossings counted in the last completed window.
- vmax  output  DATA_W  largest sample in the last window.
- vmin  output  DATA_W  smallest sample in the last window.
- vpp  output  DATA_W  vmax minus vmin.
- meas_valid  output  1  one-cycle pulse when the outputs update.
- signal_lost  output  1  last window had zero crossings.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, meas_valid 0, signal_lost 0;
  - gate counter 0; accumulators run_max=0, run_min=all-ones, edge_cnt=0;
  - threshold mid = 2^(DATA_W-1), i.e. 128; crossing FSM in ARM.
- Gate counter:
  - increments every cycle from 0 to GATE_CYCLES-1, then wraps to 0;
  - the cycle at GATE_CYCLES-1 is the terminal cycle (tc).
- Thresholds, computed with saturation:
  - hi = min(mid+HYST, 2^DATA_W-1);
  - lo = max(mid-HYST, 0).
- Crossing FSM, which advances only on sample_valid:
  - ARM: if sample >= mid go to HIGH, else go to LOW. No count.
  - LOW: if sample >= hi, go to HIGH and increment edge_cnt.
  - HIGH: if sample <= lo, go to LOW.
  - The FSM state persists across window boundaries; only the counts clear.
- edge_cnt saturates at 2^CNT_W-1 and never wraps.
- Accumulators: on each valid sample, update run_max and run_min.
- On tc:
  - The sample at tc, if valid, belongs to the closing window: it is included in the crossing, max and min that are latched.
  - freq_count <= edge_cnt, counting an edge at tc.
  - If at least one valid sample occurred in the window:
    - vmax, vmin, vpp <= run_max, run_min, run_max-run_min;
    - mid <= (run_max+run_min)>>1, using a DATA_W+1-bit sum.
  - If no valid sample occurred in the window:
    - vmax, vmin, vpp <= 0;
    - mid <= 128;
    - FSM returns to ARM.
  - signal_lost <= (latched freq_count == 0).
  - meas_valid = 1 in the cycle after tc, for exactly one cycle.
  - Accumulators reset for the next window, seeded by nothing.
- Latency: outputs are registered and valid from the cycle after tc until the next update.
- A new mid takes effect from the first cycle of the next window.
- Reset mid-window:
  - window aborted, no meas_valid;
  - gate restarts at 0 on the first clock after release.

Decomposition:
- Package wave_meter_pkg holds:
  - DATA_W default;
  - MID_RESET = 128;
  - crossing FSM state encoding {ARM, LOW, HIGH}.
- One sub-module, hyst_crossing_detector:
  - inputs: sample, valid, mid, restart;
  - output: a one-cycle rise pulse;
  - contains the FSM and the threshold saturation.
- Window counter, accumulators and output latches stay in the top level.

Test Plan:
All scenarios use GATE_CYCLES=1000, HYST=8, with sample_valid held at 1 unless noted.
1. Reset, then release:
   - all outputs 0;
   - first meas_valid exactly 1001 cycles after release.
2. Square wave 0/255, period 100 cycles, starting low:
   - freq_count=10, vmax=255, vmin=0, vpp=255, signal_lost=0;
   - next-window mid=127.
3. Toggle between 126 and 130 each cycle:
   - freq_count=0, signal_lost=1, vmax=130, vmin=126, vpp=4.
4. sample_valid=0 for a whole window:
   - vmax=vmin=vpp=0, freq_count=0, signal_lost=1;
   - following window starts from ARM with mid=128.
5. Drive reset low at gate cycle 500 of a square-wave window:
   - outputs go to 0 asynchronously, no meas_valid;
   - next meas_valid 1001 cycles after release.
6. CNT_W=4, square wave period 40 (25 edges per window):
   - freq_count=15 (saturated);
   - rising edge at tc is counted in the closing window.
